scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the cycles en_n is held low per select code (legal 1..255).
REQ-002 The block SHALL have parameter BLANK, default 1, giving the cycles en_n is held high before each select code (legal 0..255).
REQ-003 Port clk SHALL be an input, 1 bit wide, and the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and the reset, which is synchronous and active-high.
REQ-005 Port run SHALL be an input, 1 bit wide, requesting continuous scanning while high.
REQ-006 Port sel SHALL be an output, 2 bits wide, driving the downstream 2-to-4 active-low decoder select: sel[1] to the X input, sel[0] to the Y input.
REQ-007 Port en_n SHALL be an output, 1 bit wide, driving the decoder's active-low enable (Z input); 1 forces all decoder outputs inactive.
REQ-008 Port busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-009 Port frame_done SHALL be an output, 1 bit wide, carrying a one-cycle pulse after select code 3 completes its dwell.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 The FSM SHALL have states IDLE, BLANK and DRIVE, with a shared down-counter of 8 bits.
REQ-012 In IDLE, the block SHALL hold sel=0 and en_n=1, and run=1 sampled on an edge SHALL move it to BLANK, or to DRIVE if BLANK=0, on that edge.
REQ-013 In BLANK, the block SHALL hold en_n=1 for exactly BLANK cycles at the current sel, then enter DRIVE.
REQ-014 In DRIVE, the block SHALL hold en_n=0 for exactly DWELL cycles at the current sel.
REQ-015 At the end of DRIVE with sel<3, the block SHALL set sel to sel+1 and enter BLANK, or DRIVE again if BLANK=0.
REQ-016 At the end of DRIVE with sel=3, the block SHALL pulse frame_done for one cycle, wrap sel to 0, and then enter BLANK (or DRIVE) if run=1, otherwise IDLE.
REQ-017 Frame length SHALL be 4*(BLANK+DWELL) cycles, and consecutive frames SHALL have no gap cycles.
REQ-018 sel SHALL change only while en_n=1 when BLANK>=1, so that no decoder glitch is exposed.
REQ-019 If run falls mid-frame, the block SHALL complete the current frame (through sel=3) before entering IDLE, and SHALL NOT abort it.
REQ-020 If run rises while in IDLE on the same edge that IDLE was entered, the block SHALL start a new frame on the next edge.
REQ-021 The counter SHALL never underflow, and a reload SHALL occur on every state entry.

Reset
REQ-022 When rst=1 is sampled on an edge, the block SHALL set state=IDLE, sel=0, en_n=1, busy=0, frame_done=0, counter=0 and (if compiled in) frame_cnt=0, regardless of the current state.
REQ-023 A reset in the middle of DRIVE SHALL bring en_n high on the same edge, with no completing frame_done pulse.

Configuration
REQ-024 When the macro SCAN_FRAME_CNT_EN is defined, the block SHALL add output frame_cnt, 8 bits wide, which increments on every frame_done pulse and wraps from 255 to 0.
REQ-025 When SCAN_FRAME_CNT_EN is undefined, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package scan_pkg SHALL hold the state enum (IDLE, BLANK, DRIVE), the CNT_W=8 constant and the SEL_LAST=2'd3 constant.
REQ-027 The block SHALL have one sub-module, dwell_timer, a loadable 8-bit down-counter with a zero flag, instantiated once.

Verification
REQ-028 Reset check: apply rst=1 for 2 cycles with run=1 -> sel=0, en_n=1, busy=0 and frame_done=0 throughout.
REQ-029 Single frame (DWELL=4, BLANK=1): pulse run high for 1 cycle -> en_n pattern 1,0,0,0,0 repeated for sel 0,1,2,3, one frame_done pulse at cycle 21, then IDLE with busy=0.
REQ-030 Continuous run: hold run=1 for 3 frames -> 60 cycles, frame_done every 20 cycles, sel wraps 3->0 with no gap and frame_cnt reads 3.
REQ-031 BLANK=0, DWELL=1: hold run=1 -> en_n stays 0, sel steps 0,1,2,3,0 every cycle, and frame_done occurs every 4 cycles.
REQ-032 Mid-operation reset: assert rst during DRIVE at sel=2 -> en_n=1, sel=0 and busy=0 on the next edge, with no frame_done pulse.
REQ-033 frame_cnt wrap: run for 256 frames with SCAN_FRAME_CNT_EN defined -> frame_cnt=0 after frame 256.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding,
// dwell counter width and the last decoder select code.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int         CNT_W    = 8;
    localparam logic [1:0] SEL_LAST = 2'd3;

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Loadable down-counter with a zero flag; shared by the BLANK and DRIVE
// phases. Decrement saturates at zero so the count can never wrap.
module dwell_timer
    import scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Scans a 2-to-4 active-low decoder: per select code, BLANK cycles with the
// enable off, then DWELL cycles with it on. Optional frame counter output
// is compiled in with SCAN_FRAME_CNT_EN.
module scan_sequencer
    import scan_pkg::state_t, scan_pkg::CNT_W, scan_pkg::SEL_LAST,
           scan_pkg::IDLE, scan_pkg::DRIVE;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [1:0]       sel,
    output logic             en_n,
    output logic             busy,
    output logic             frame_done
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_cnt
`endif
);

    // The BLANK state literal is package-qualified because the parameter
    // shares its name.
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK == 0) ? '0 : CNT_W'(BLANK - 1);
    localparam state_t           FIRST_ST = (BLANK == 0) ? DRIVE : scan_pkg::BLANK;
    localparam logic [CNT_W-1:0] FIRST_LD = (BLANK == 0) ? DWELL_LD : BLANK_LD;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             dec;
    logic             zero;

    dwell_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ld),
        .load_val_i(ld_val),
        .dec_i     (dec),
        .zero_o    (zero)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        ld           = 1'b0;
        ld_val       = '0;
        dec          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FIRST_ST;
                    sel_d   = '0;
                    ld      = 1'b1;
                    ld_val  = FIRST_LD;
                end
            end
            scan_pkg::BLANK: begin
                if (zero) begin
                    state_d = DRIVE;
                    ld      = 1'b1;
                    ld_val  = DWELL_LD;
                end else begin
                    dec = 1'b1;
                end
            end
            DRIVE: begin
                if (!zero) begin
                    dec = 1'b1;
                end else if (sel_q != SEL_LAST) begin
                    sel_d   = sel_q + 2'd1;
                    state_d = FIRST_ST;
                    ld      = 1'b1;
                    ld_val  = FIRST_LD;
                end else begin
                    // Frame end: run is only consulted here, so a frame is never cut short.
                    frame_done_d = 1'b1;
                    sel_d        = '0;
                    ld           = 1'b1;
                    if (run) begin
                        state_d = FIRST_ST;
                        ld_val  = FIRST_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                ld      = 1'b1;
            end
        endcase
        en_n_d = (state_d != DRIVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            en_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_n_q       <= en_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign en_n       = en_n_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

`ifdef SCAN_FRAME_CNT_EN
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_d) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: three parameterisations checked every cycle
// against a frame-position model, plus a directed table and corner sequences.
module tb_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, run_v;
    logic [1:0] sel_w [3];
    logic [2:0] en_n_w, busy_w, fd_w;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0] fcnt_w [3];
`endif

    int nvec = 0;
    int nmis = 0;

    int dw_m [3] = '{4, 1, 3};
    int bl_m [3] = '{1, 0, 2};

    scan_sequencer #(.DWELL(4), .BLANK(1)) u_d0 (
        .clk(clk), .rst(rst_v[0]), .run(run_v[0]), .sel(sel_w[0]),
        .en_n(en_n_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0])
`ifdef SCAN_FRAME_CNT_EN
        , .frame_cnt(fcnt_w[0])
`endif
    );
    scan_sequencer #(.DWELL(1), .BLANK(0)) u_d1 (
        .clk(clk), .rst(rst_v[1]), .run(run_v[1]), .sel(sel_w[1]),
        .en_n(en_n_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1])
`ifdef SCAN_FRAME_CNT_EN
        , .frame_cnt(fcnt_w[1])
`endif
    );
    scan_sequencer #(.DWELL(3), .BLANK(2)) u_d2 (
        .clk(clk), .rst(rst_v[2]), .run(run_v[2]), .sel(sel_w[2]),
        .en_n(en_n_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2])
`ifdef SCAN_FRAME_CNT_EN
        , .frame_cnt(fcnt_w[2])
`endif
    );

    // Model: a frame is a position 0..4*(BLANK+DWELL)-1; outputs follow from it.
    bit m_act [3];
    int m_pos [3];
    bit m_fd  [3];
    int m_fc  [3];
    int fd_seen   [3];
    int enhi_seen [3];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int len;
            len = 4 * (bl_m[i] + dw_m[i]);
            if (rst_v[i]) begin
                m_act[i] = 0; m_pos[i] = 0; m_fd[i] = 0; m_fc[i] = 0;
            end else if (m_act[i]) begin
                if (m_pos[i] == len - 1) begin
                    m_fd[i] = 1;
                    m_fc[i] = (m_fc[i] + 1) % 256;
                    m_pos[i] = 0;
                    if (!run_v[i]) m_act[i] = 0;
                end else begin
                    m_fd[i] = 0;
                    m_pos[i]++;
                end
            end else begin
                m_fd[i] = 0;
                if (run_v[i]) begin
                    m_act[i] = 1; m_pos[i] = 0;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int per, e_sel;
            bit e_en_n;
            per = bl_m[i] + dw_m[i];
            if (m_act[i]) begin
                e_sel  = m_pos[i] / per;
                e_en_n = (m_pos[i] % per) < bl_m[i];
            end else begin
                e_sel  = 0;
                e_en_n = 1;
            end
            chk($sformatf("u%0d.sel", i), 32'(sel_w[i]), 32'(e_sel));
            chk($sformatf("u%0d.en_n", i), 32'(en_n_w[i]), 32'(e_en_n));
            chk($sformatf("u%0d.busy", i), 32'(busy_w[i]), 32'(m_act[i]));
            chk($sformatf("u%0d.frame_done", i), 32'(fd_w[i]), 32'(m_fd[i]));
`ifdef SCAN_FRAME_CNT_EN
            chk($sformatf("u%0d.frame_cnt", i), 32'(fcnt_w[i]), 32'(m_fc[i]));
`endif
            if (fd_w[i] === 1'b1) fd_seen[i]++;
            if (en_n_w[i] === 1'b1) enhi_seen[i]++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       run;
        int         n;
        logic [1:0] sel;
        logic       en_n;
        logic       busy;
        logic       fd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic u, int n, logic [1:0] s,
                                logic e, logic b, logic f);
        vec_t v;
        v.rst = r; v.run = u; v.n = n; v.sel = s; v.en_n = e; v.busy = b; v.fd = f;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_v = 3'b111;
        run_v = 3'b000;

        // Directed expectations for the DWELL=4, BLANK=1 instance.
        add(1, 1, 2,  2'd0, 1, 0, 0);
        add(0, 1, 1,  2'd0, 1, 1, 0);
        add(0, 0, 1,  2'd0, 0, 1, 0);
        add(0, 0, 3,  2'd0, 0, 1, 0);
        add(0, 0, 1,  2'd1, 1, 1, 0);
        add(0, 0, 1,  2'd1, 0, 1, 0);
        add(0, 0, 8,  2'd2, 0, 1, 0);
        add(0, 0, 1,  2'd3, 1, 1, 0);
        add(0, 0, 4,  2'd3, 0, 1, 0);
        add(0, 0, 1,  2'd0, 1, 0, 1);
        add(0, 0, 1,  2'd0, 1, 0, 0);
        // reset during DRIVE at sel=2
        add(0, 1, 1,  2'd0, 1, 1, 0);
        add(0, 0, 11, 2'd2, 0, 1, 0);
        add(1, 0, 1,  2'd0, 1, 0, 0);
        add(0, 0, 1,  2'd0, 1, 0, 0);
        // run rises on the cycle IDLE is entered
        add(0, 1, 1,  2'd0, 1, 1, 0);
        add(0, 0, 19, 2'd3, 0, 1, 0);
        add(0, 0, 1,  2'd0, 1, 0, 1);
        add(0, 1, 1,  2'd0, 1, 1, 0);
        add(0, 0, 1,  2'd0, 0, 1, 0);
        add(0, 0, 19, 2'd0, 1, 0, 1);

        foreach (tbl[k]) begin
            rst_v = {2'b11, tbl[k].rst};
            run_v = {2'b00, tbl[k].run};
            for (int c = 0; c < tbl[k].n; c++) step();
            chk($sformatf("tbl[%0d].sel", k), 32'(sel_w[0]), 32'(tbl[k].sel));
            chk($sformatf("tbl[%0d].en_n", k), 32'(en_n_w[0]), 32'(tbl[k].en_n));
            chk($sformatf("tbl[%0d].busy", k), 32'(busy_w[0]), 32'(tbl[k].busy));
            chk($sformatf("tbl[%0d].frame_done", k), 32'(fd_w[0]), 32'(tbl[k].fd));
        end

        // Reset held with run high, then continuous scanning for three frames.
        rst_v = 3'b111;
        run_v = 3'b111;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            fd_seen[i] = 0;
            enhi_seen[i] = 0;
        end
        rst_v = 3'b000;
        for (int c = 0; c < 61; c++) step();
        chk("cont.u0_frames", 32'(fd_seen[0]), 32'd3);
        chk("cont.u1_frames", 32'(fd_seen[1]), 32'd15);
        chk("cont.u2_frames", 32'(fd_seen[2]), 32'd3);
        chk("cont.u1_en_n_high", 32'(enhi_seen[1]), 32'd0);
`ifdef SCAN_FRAME_CNT_EN
        chk("cont.u0_frame_cnt", 32'(fcnt_w[0]), 32'd3);
`endif

        // 256 back-to-back frames on the 4-cycle-frame instance.
        rst_v = 3'b111;
        step();
        for (int i = 0; i < 3; i++) fd_seen[i] = 0;
        rst_v = 3'b000;
        for (int c = 0; c < 1025; c++) step();
        chk("wrap.u1_frames", 32'(fd_seen[1]), 32'd256);
`ifdef SCAN_FRAME_CNT_EN
        chk("wrap.u1_frame_cnt", 32'(fcnt_w[1]), 32'd0);
`endif

        // Random run toggling with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 99) < 8) run_v[i] = ~run_v[i];
                rst_v[i] = ($urandom_range(0, 299) == 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
